// File: rtl/dr_fetch_bridge_if.sv
// Dual-rail fetch/push channel bundle.
// master = bridge side, slave = producer/consumer side.
interface dr_fetch_bridge_if #(
  parameter int W = 32
);
  logic         i_0r;
  logic [W-1:0] i_0a0d;
  logic [W-1:0] i_0a1d;
  logic [W-1:0] o_0r0d;
  logic [W-1:0] o_0r1d;
  logic         o_0a;

  modport master (
    output i_0r,
    output o_0r0d,
    output o_0r1d,
    input  i_0a0d,
    input  i_0a1d,
    input  o_0a
  );

  modport slave (
    input  i_0r,
    input  o_0r0d,
    input  o_0r1d,
    output i_0a0d,
    output i_0a1d,
    output o_0a
  );
endinterface

// File: rtl/dr_fetch_bridge.sv
// Dual-rail fetch bridge: pulls words from a passive dual-rail
// producer into a DEPTH-word FIFO and pushes them out as dual-rail
// four-phase transfers to a passive consumer.
// Ports: clk, nreset (async active-low), enable (permit fetches),
//   bus (dr_fetch_bridge_if.master: i_0r, i_0a0d/1d, o_0r0d/1d, o_0a),
//   level (buffered word count), rail_err (sticky rail conflict).
// Optional: DR_FETCH_RAILCHK_EN enables rail-conflict detection.
module dr_fetch_bridge #(
  parameter int W           = 32,
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic                         enable,
  dr_fetch_bridge_if.master            bus,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         rail_err
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_NULL
  } f_state_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_DATA,
    P_RTZ
  } p_state_e;

  // Reset: asserts at once, releases after SYNC_STAGES edges.
  logic [SYNC_STAGES-1:0] rst_q;
  logic                   rst_n;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rst_q <= '0;
    end else begin
      rst_q <= {rst_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_n = rst_q[SYNC_STAGES-1];

  // Input synchronisers.
  logic [SYNC_STAGES-1:0][W-1:0] s0_q;
  logic [SYNC_STAGES-1:0][W-1:0] s1_q;
  logic [SYNC_STAGES-1:0]        sa_q;
  logic [W-1:0]                  p0_q;
  logic [W-1:0]                  p1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q <= '0;
      s1_q <= '0;
      sa_q <= '0;
      p0_q <= '0;
      p1_q <= '0;
    end else begin
      s0_q <= {s0_q[SYNC_STAGES-2:0], bus.i_0a0d};
      s1_q <= {s1_q[SYNC_STAGES-2:0], bus.i_0a1d};
      sa_q <= {sa_q[SYNC_STAGES-2:0], bus.o_0a};
      p0_q <= s0_q[SYNC_STAGES-1];
      p1_q <= s1_q[SYNC_STAGES-1];
    end
  end

  logic [W-1:0] s0;
  logic [W-1:0] s1;
  logic         sa;
  logic         stable;
  logic         complete;
  logic         bad;
  logic         all_zero;

  assign s0 = s0_q[SYNC_STAGES-1];
  assign s1 = s1_q[SYNC_STAGES-1];
  assign sa = sa_q[SYNC_STAGES-1];

  // Code must hold for two consecutive samples.
  assign stable   = (s0 == p0_q) && (s1 == p1_q);
  assign all_zero = ~|{s0, s1};

`ifdef DR_FETCH_RAILCHK_EN
  assign bad      = |(s0 & s1);
  assign complete = stable && (&(s0 ^ s1));
`else
  assign bad      = 1'b0;
  assign complete = stable && (&(s0 | s1));
`endif

  // FIFO state.
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] wr_ptr_d;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_ptr_d;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;

  f_state_e     f_q;
  p_state_e     p_q;
  logic         i_0r_q;
  logic         err_q;
  logic [W-1:0] o0_q;
  logic [W-1:0] o1_q;
  logic         wr_en;
  logic         pop;

  assign wr_en = (f_q == F_REQ) && !bad && complete;
  assign pop   = (p_q == P_RTZ) && !sa;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = nxt(wr_ptr_q);
    if (pop)   rd_ptr_d = nxt(rd_ptr_q);
    unique case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (wr_en) mem_q[wr_ptr_q] <= s1;
    end
  end

  // Fetch FSM. enable is only looked at in F_IDLE,
  // so a started transaction always completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q    <= F_IDLE;
      i_0r_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      unique case (f_q)
        F_IDLE: begin
          if (enable && (level_q < DEPTH_L)) begin
            f_q    <= F_REQ;
            i_0r_q <= 1'b1;
          end
        end
        F_REQ: begin
          if (bad) begin
            err_q  <= 1'b1;
            i_0r_q <= 1'b0;
            f_q    <= F_NULL;
          end else if (complete) begin
            i_0r_q <= 1'b0;
            f_q    <= F_NULL;
          end
        end
        F_NULL: begin
          if (all_zero) f_q <= F_IDLE;
        end
        default: begin
          f_q    <= F_IDLE;
          i_0r_q <= 1'b0;
        end
      endcase
    end
  end

  // Push FSM. Rails only move on IDLE->DATA and DATA->RTZ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q  <= P_IDLE;
      o0_q <= '0;
      o1_q <= '0;
    end else begin
      unique case (p_q)
        P_IDLE: begin
          if (level_q != '0) begin
            p_q  <= P_DATA;
            o1_q <= mem_q[rd_ptr_q];
            o0_q <= ~mem_q[rd_ptr_q];
          end
        end
        P_DATA: begin
          if (sa) begin
            p_q  <= P_RTZ;
            o0_q <= '0;
            o1_q <= '0;
          end
        end
        P_RTZ: begin
          if (!sa) p_q <= P_IDLE;
        end
        default: begin
          p_q  <= P_IDLE;
          o0_q <= '0;
          o1_q <= '0;
        end
      endcase
    end
  end

  assign bus.i_0r   = i_0r_q;
  assign bus.o_0r0d = o0_q;
  assign bus.o_0r1d = o1_q;
  assign level      = level_q;

`ifdef DR_FETCH_RAILCHK_EN
  assign rail_err = err_q;
`else
  assign rail_err = 1'b0;
`endif

endmodule

// File: tb/tb_dr_fetch_bridge.sv
// Scoreboard bench for dr_fetch_bridge (W=32, DEPTH=2).
// Producer/consumer models drive the dual-rail channel.
module tb_dr_fetch_bridge;

  logic       clk;
  logic       nreset;
  logic       enable;
  logic [1:0] level;
  logic       rail_err;
  logic       ack_en;

  int checks = 0;
  int passes = 0;

  logic [31:0] q[$];

  dr_fetch_bridge_if #(.W(32)) bus();

  dr_fetch_bridge #(
    .W(32),
    .DEPTH(2),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .nreset(nreset),
    .enable(enable),
    .bus(bus),
    .level(level),
    .rail_err(rail_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic tmo(input string name);
    checks++;
    $display("FAIL %s: timeout got 0 want 1", name);
  endtask

  task automatic wait_req(input logic v, input string name);
    for (int n = 0; n < 400 && bus.i_0r !== v; n++)
      @(negedge clk);
    if (bus.i_0r !== v) tmo(name);
  endtask

  task automatic wait_level(input logic [1:0] v, input string name);
    for (int n = 0; n < 1000 && level !== v; n++)
      @(negedge clk);
    chk(name, {30'd0, level}, {30'd0, v});
  endtask

  task automatic produce_raw(
    input logic [31:0] r0,
    input logic [31:0] r1,
    input logic        push,
    input logic [31:0] exp
  );
    wait_req(1'b1, "req_rise");
    if (push) q.push_back(exp);
    bus.i_0a0d = r0;
    bus.i_0a1d = r1;
    wait_req(1'b0, "req_fall");
    bus.i_0a0d = '0;
    bus.i_0a1d = '0;
    @(negedge clk);
  endtask

  task automatic produce(input logic [31:0] w);
    produce_raw(~w, w, 1'b1, w);
  endtask

  // Consumer: acks valid data when allowed, drops ack on null.
  initial begin
    bus.o_0a = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_en && (&(bus.o_0r0d ^ bus.o_0r1d)))
        bus.o_0a = 1'b1;
      else if ((bus.o_0r0d | bus.o_0r1d) == '0)
        bus.o_0a = 1'b0;
    end
  end

  // Monitor: compares each new dual-rail word with the queue.
  initial begin
    logic        pv;
    logic        v;
    logic [31:0] e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      v = &(bus.o_0r0d ^ bus.o_0r1d);
      if (v && !pv) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL out_unexp: got %h want none",
                   bus.o_0r1d);
        end else begin
          e = q.pop_front();
          chk("out_r1", bus.o_0r1d, e);
          chk("out_r0", bus.o_0r0d, ~e);
        end
      end
      pv = v;
    end
  end

  initial begin
    nreset     = 1'b1;
    enable     = 1'b0;
    ack_en     = 1'b0;
    bus.i_0a0d = '0;
    bus.i_0a1d = '0;
    #3 nreset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_i_0r", {31'd0, bus.i_0r}, 32'd0);
    chk("rst_o1", bus.o_0r1d, 32'd0);
    chk("rst_o0", bus.o_0r0d, 32'd0);
    chk("rst_level", {30'd0, level}, 32'd0);
    chk("rst_err", {31'd0, rail_err}, 32'd0);
    nreset = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_i_0r", {31'd0, bus.i_0r}, 32'd0);

    // Single fetch, consumer holding off.
    enable = 1'b1;
    produce(32'hDEADBEEF);
    chk("w1_level", {30'd0, level}, 32'd1);
    repeat (4) @(negedge clk);
    chk("w1_o1", bus.o_0r1d, 32'hDEADBEEF);
    chk("w1_o0", bus.o_0r0d, 32'h21524110);
    ack_en = 1'b1;
    wait_level(2'd0, "w1_drain");

    // Fill the FIFO with acks withheld.
    ack_en = 1'b0;
    produce(32'h1);
    produce(32'h2);
    chk("full_level", {30'd0, level}, 32'd2);
    repeat (10) @(negedge clk);
    chk("full_no_req", {31'd0, bus.i_0r}, 32'd0);
    chk("full_level2", {30'd0, level}, 32'd2);
    ack_en = 1'b1;
    wait_req(1'b1, "pop_req");
    chk("pop_level", {30'd0, level}, 32'd1);

    // Stream four words through, wrapping pointers.
    produce(32'hA);
    produce(32'hB);
    produce(32'hC);
    produce(32'hD);
    wait_level(2'd0, "stream_drain");
    repeat (20) @(negedge clk);
    chk("stream_q", q.size(), 32'd0);

    // enable drops mid-request: word still lands.
    wait_req(1'b1, "en_req");
    enable = 1'b0;
    produce(32'h55);
    repeat (20) @(negedge clk);
    chk("en_off_req", {31'd0, bus.i_0r}, 32'd0);
    wait_level(2'd0, "en_drain");
    chk("en_off_req2", {31'd0, bus.i_0r}, 32'd0);
    enable = 1'b1;
    wait_req(1'b1, "en_on_req");

    // Both rails of bit 3 high.
    ack_en = 1'b0;
`ifdef DR_FETCH_RAILCHK_EN
    produce_raw(32'hFFFFFFFF, 32'h8, 1'b0, 32'h0);
    chk("conf_err", {31'd0, rail_err}, 32'd1);
    chk("conf_level", {30'd0, level}, 32'd0);
    produce(32'h7);
    chk("clean_level", {30'd0, level}, 32'd1);
    chk("clean_err", {31'd0, rail_err}, 32'd1);
`else
    produce_raw(32'hFFFFFFFF, 32'h8, 1'b1, 32'h8);
    chk("conf_err", {31'd0, rail_err}, 32'd0);
    chk("conf_level", {30'd0, level}, 32'd1);
    produce(32'h7);
    chk("clean_level", {30'd0, level}, 32'd2);
    chk("clean_err", {31'd0, rail_err}, 32'd0);
`endif
    ack_en = 1'b1;
    wait_level(2'd0, "conf_drain");

    // Reset while 0x99 sits on the output rails.
    ack_en = 1'b0;
    produce(32'h99);
    for (int n = 0; n < 50 && bus.o_0r1d !== 32'h99; n++)
      @(negedge clk);
    chk("pre_rst_o1", bus.o_0r1d, 32'h99);
    nreset = 1'b0;
    #1;
    chk("mid_rst_o1", bus.o_0r1d, 32'd0);
    chk("mid_rst_o0", bus.o_0r0d, 32'd0);
    chk("mid_rst_req", {31'd0, bus.i_0r}, 32'd0);
    chk("mid_rst_level", {30'd0, level}, 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_level", {30'd0, level}, 32'd0);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    chk("end_q", q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
